// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: MEM-stage state encoding,
// datapath widths and the MEM->WB write-back bundle.
package mips_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mau_state_e;

  typedef struct packed {
    logic              regwr;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  localparam wb_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_access_unit.sv
// MEM stage: runs loads/stores on a valid/ready data bus,
// stalls upstream while busy, registers the write-back bundle.
module mem_access_unit
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memWr_MEM,
  input  logic              regWr_MEM,
  input  logic              Wrback_MEM,
  input  logic [DATA_W-1:0] AluResult_MEM,
  input  logic [DATA_W-1:0] WriteMemData_MEM,
  input  logic [REG_AW-1:0] WriteReg_MEM,
  output logic              stall_o,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [DATA_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic              regWr_WB,
  output logic [REG_AW-1:0] WriteReg_WB,
  output logic [DATA_W-1:0] WriteData_WB,
  output logic              err_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  mau_state_e        state_q, state_d;
  wb_t               wb_q, wb_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic mem_op;
  logic misal;
  logic to_hit;

  assign mem_op = memWr_MEM | Wrback_MEM;
  assign misal  = |AluResult_MEM[1:0];
  assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wb_q    <= WB_BUBBLE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wb_d    = WB_BUBBLE;
    err_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (!mem_op) begin
          wb_d = '{regWr_MEM, WriteReg_MEM, AluResult_MEM};
        end else if (misal) begin
          err_d = 1'b1;
        end else begin
          we_d    = memWr_MEM;
          addr_d  = {AluResult_MEM[DATA_W-1:2], 2'b00};
          wdata_d = WriteMemData_MEM;
          rd_d    = WriteReg_MEM;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A store finishes on acceptance; a load still needs its response.
        if (req_ready && we_q) begin
          state_d = DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rsp_valid) begin
          wb_d    = '{regWr_MEM, rd_q, rsp_rdata};
          state_d = DONE;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_valid    = (state_q == REQ);
    stall_o      = rst_n &&
                   ((state_q == REQ) || (state_q == WAIT) ||
                    ((state_q == IDLE) && mem_op && !misal));
    req_we       = we_q;
    req_addr     = addr_q;
    req_wdata    = wdata_q;
    regWr_WB     = wb_q.regwr;
    WriteReg_WB  = wb_q.rd;
    WriteData_WB = wb_q.data;
    err_o        = err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random op
// stream against a transaction-level expectation model.
module tb_mem_access_unit;
  import mips_pipe_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memWr_MEM = 0, regWr_MEM = 0, Wrback_MEM = 0;
  logic [31:0] AluResult_MEM = 0, WriteMemData_MEM = 0;
  logic [4:0]  WriteReg_MEM = 0;
  logic        stall_o, req_valid, req_we, regWr_WB, err_o;
  logic        req_ready = 0, rsp_valid = 0;
  logic [31:0] req_addr, req_wdata, rsp_rdata = 0, WriteData_WB;
  logic [4:0]  WriteReg_WB;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memWr_MEM(memWr_MEM), .regWr_MEM(regWr_MEM),
    .Wrback_MEM(Wrback_MEM), .AluResult_MEM(AluResult_MEM),
    .WriteMemData_MEM(WriteMemData_MEM),
    .WriteReg_MEM(WriteReg_MEM), .stall_o(stall_o),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .regWr_WB(regWr_WB),
    .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
    .err_o(err_o)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [36:0] exp_wb[$];
  int exp_err = 0;
  int obs_err = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Every write-back the DUT performs must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_o) obs_err++;
      if (regWr_WB) begin
        if (exp_wb.size() == 0) chk("wb_extra", exp_wb.size(), 1);
        else chk("wb", {WriteReg_WB, WriteData_WB}, exp_wb.pop_front());
      end
    end
  end

  // hang: 0 none, 1 never ready, 2 load never answered
  task automatic run_op(bit we, bit wb, bit rw, logic [4:0] rd,
                        logic [31:0] addr, logic [31:0] wdata,
                        logic [31:0] rdata, int rdly, int sdly,
                        int hang, bit junk);
    bit mem, mis, load, acc, acc_now;
    int exp_stall, exp_reqc, stalls, reqc, seen, rcnt;
    mem  = we | wb;
    mis  = addr[1:0] != 2'b00;
    load = !we && wb;
    exp_stall = 0;
    exp_reqc  = 0;
    if (!mem) begin
      if (rw) exp_wb.push_back({rd, addr});
    end else if (mis) begin
      exp_err++;
    end else if (hang != 0) begin
      exp_err++;
      exp_stall = 1 + TO;
      exp_reqc  = (hang == 1) ? TO : rdly + 1;
    end else begin
      exp_stall = 2 + rdly + (load ? sdly + 1 : 0);
      exp_reqc  = rdly + 1;
      if (load && rw) exp_wb.push_back({rd, rdata});
    end
    memWr_MEM = we; Wrback_MEM = wb; regWr_MEM = rw;
    WriteReg_MEM = rd; AluResult_MEM = addr;
    WriteMemData_MEM = wdata;
    acc = 0; stalls = 0; reqc = 0; seen = 0; rcnt = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      req_ready = 0;
      rsp_valid = 0;
      rsp_rdata = $urandom;
      acc_now = 0;
      if (junk) begin
        req_ready = 1;
        rsp_valid = 1;
      end else if (req_valid && !acc) begin
        req_ready = (hang != 1) && (seen >= rdly);
        seen++;
      end else if (acc && load && hang != 2) begin
        rsp_valid = (rcnt == sdly);
        if (rsp_valid) rsp_rdata = rdata;
        rcnt++;
      end
      @(negedge clk);
      if (req_valid) begin
        reqc++;
        chk("req_addr", req_addr, {addr[31:2], 2'b00});
        chk("req_we", req_we, we);
        chk("req_wdata", req_wdata, wdata);
        if (req_ready) acc_now = 1;
      end
      if (!stall_o) break;
      stalls++;
      @(posedge clk); #1;
      if (acc_now) acc = 1;
    end
    @(posedge clk); #1;
    chk("stall_cycles", stalls, exp_stall);
    chk("req_cycles", reqc, exp_reqc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit we, wb, rw, jk;
    int k, hg;
    logic [31:0] a;
    #1;
    chk("rst_ctl", {stall_o, req_valid, req_we, regWr_WB,
                    err_o, WriteReg_WB}, 0);
    chk("rst_data", {req_addr, WriteData_WB}, 0);
    chk("rst_wdata", req_wdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // ALU pass-through, aligned load, slow store, misaligned load
    run_op(0, 0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0);
    run_op(0, 1, 1, 9, 32'h100, 0, 32'hCAFEF00D, 0, 0, 0, 0);
    run_op(1, 0, 1, 3, 32'h40, 32'hA5A5A5A5, 0, 4, 0, 0, 0);
    run_op(0, 1, 1, 4, 32'h102, 0, 0, 0, 0, 0, 0);
    // timeouts, then a late response that must be ignored
    run_op(0, 1, 1, 6, 32'h80, 0, 32'h1, 1, 0, 2, 0);
    run_op(0, 0, 1, 2, 32'h55, 0, 0, 0, 0, 0, 1);
    run_op(1, 1, 1, 8, 32'h84, 32'h77, 0, 0, 0, 1, 0);
    // completion on the very cycle the timeout would fire
    run_op(0, 1, 1, 10, 32'h90, 0, 32'hBEEF, 3, 3, 0, 0);

    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 3);
      we = (k == 2) || (k == 3);
      wb = (k == 1) || (k == 3);
      rw = $urandom_range(0, 3) != 0;
      a  = $urandom & 32'hFFFF;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      hg = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      if (!(!we && wb) && hg == 2) hg = 1;
      jk = (!(we | wb) || a[1:0] != 0) && $urandom_range(0, 1);
      run_op(we, wb, rw, 5'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), hg, jk);
    end

    // reset while a load sits in WAIT
    memWr_MEM = 0; Wrback_MEM = 1; regWr_MEM = 1;
    WriteReg_MEM = 7; AluResult_MEM = 32'h200;
    @(posedge clk); #1 req_ready = 1;
    @(posedge clk); #1 req_ready = 0;
    chk("wait_stall", stall_o, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_req_valid", req_valid, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_regwr", regWr_WB, 0);
    Wrback_MEM = 0; regWr_MEM = 0;
    rsp_valid = 1; rsp_rdata = 32'hDEAD;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_stall", stall_o, 0);
    chk("post_rst_req", req_valid, 0);
    @(posedge clk); #1 rsp_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("err_count", obs_err, exp_err);
    chk("wb_left", exp_wb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
